// File: rtl/puf_eval_ctrl.sv
// Ring-oscillator PUF evaluation sequencer: for each response bit it steers both muxes, counts RO edges over a window and compares.
// Define PUF_TIE_FLAG_EN to add the tie_mask output flagging equal counts.
module puf_eval_ctrl #(
  parameter int N_BITS        = 8,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        chall_in,
  input  logic              ro_a,
  input  logic              ro_b,
  output logic [2:0]        sel_a,
  output logic [2:0]        sel_b,
  output logic              ro_en,
  output logic              busy,
  output logic              ready,
  output logic [N_BITS-1:0] response
`ifdef PUF_TIE_FLAG_EN
  ,
  output logic [N_BITS-1:0] tie_mask
`endif
);

  localparam int TIMER_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int IDX_W     = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(N_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, COUNT, COMPARE, DONE} state_t;

  state_t             state, next_state;
  logic [TIMER_W-1:0] timer;
  logic [IDX_W-1:0]   idx;
  logic [2:0]         chall_a_q, chall_b_q;
  logic [1:0]         a_sync, b_sync;
  logic               a_prev, b_prev;
  logic               a_rise, b_rise;
  logic [CNT_W-1:0]   cnt_a, cnt_b;
  logic               unused_chall;

  // Challenge bits 4:3 steer neither mux.
  assign unused_chall = ^chall_in[4:3];

  // Two-flop synchronizers plus an edge-detect flop. The edge-detect flop is
  // forced high during SETTLE so a transition spanning a mux switch never counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sync <= '0;
      b_sync <= '0;
      a_prev <= 1'b0;
      b_prev <= 1'b0;
    end else begin
      a_sync <= {a_sync[0], ro_a};
      b_sync <= {b_sync[0], ro_b};
      a_prev <= (state == SETTLE) | a_sync[1];
      b_prev <= (state == SETTLE) | b_sync[1];
    end
  end

  assign a_rise = a_sync[1] & ~a_prev;
  assign b_rise = b_sync[1] & ~b_prev;

  // Saturating edge counters, cleared while the muxes settle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (state == SETTLE) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (state == COUNT) begin
      if (a_rise && cnt_a != '1) cnt_a <= cnt_a + 1'b1;
      if (b_rise && cnt_b != '1) cnt_b <= cnt_b + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: next_state gets its default first, so no path through the case can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SETTLE;
      SETTLE:  if (timer == SETTLE_LAST) next_state = COUNT;
      COUNT:   if (timer == WINDOW_LAST) next_state = COMPARE;
      COMPARE: next_state = (idx == IDX_LAST) ? DONE : SETTLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    timer <= '0;
    else if (state == IDLE || state != next_state) timer <= '0;
    else                                         timer <= timer + 1'b1;
  end

  // Registered outputs and per-bit bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      chall_a_q <= '0;
      chall_b_q <= '0;
      sel_a     <= '0;
      sel_b     <= '0;
      ro_en     <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      response  <= '0;
`ifdef PUF_TIE_FLAG_EN
      tie_mask  <= '0;
`endif
    end else begin
      ro_en <= (next_state == SETTLE) || (next_state == COUNT);
      busy  <= (next_state != IDLE);
      case (state)
        IDLE: if (start) begin
          chall_a_q <= chall_in[2:0];
          chall_b_q <= chall_in[7:5];
          sel_a     <= chall_in[2:0];
          sel_b     <= chall_in[7:5];
          idx       <= '0;
          response  <= '0;
          ready     <= 1'b0;
`ifdef PUF_TIE_FLAG_EN
          tie_mask  <= '0;
`endif
        end
        COMPARE: begin
          response[idx] <= (cnt_a > cnt_b);
`ifdef PUF_TIE_FLAG_EN
          tie_mask[idx] <= (cnt_a == cnt_b);
`endif
          if (idx != IDX_LAST) begin
            idx   <= idx + 1'b1;
            sel_a <= chall_a_q + 3'(idx) + 3'd1;
            sel_b <= chall_b_q + 3'(idx) + 3'd1;
          end
        end
        DONE:    ready <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: oscillator banks modelled as rate classes, responses predicted from relative rates.
// A second instance with CNT_W=3 exercises counter saturation on the same stimulus.
module tb_puf_eval_ctrl;

  localparam int NB       = 8;
  localparam int WC       = 16;
  localparam int SC       = 2;
  localparam int BIT_CYC  = SC + WC + 1;
  localparam int DONE_LAT = NB * BIT_CYC + 1;
  localparam int MAX_WAIT = 400;

  logic       clk = 1'b0;
  logic       rst, start, ro_a, ro_b;
  logic [7:0] chall_in;
  logic [2:0] sel_a, sel_b, s_sel_a, s_sel_b;
  logic       ro_en, busy, ready, s_ro_en, s_busy, s_ready;
  logic [7:0] response, s_response;
`ifdef PUF_TIE_FLAG_EN
  logic [7:0] tie_mask, s_tie_mask;
`endif

  int total = 0;
  int bad   = 0;

  // Rate class per oscillator: 0 static, 1 toggles every 4 clk, 2 every 2 clk, 3 every clk.
  // Over a 16-cycle window these give 0, 1-2, 3-4 and 7-8 rising edges, so distinct
  // classes always order strictly and equal classes share one waveform (exact tie).
  logic [1:0] cls_a [8];
  logic [1:0] cls_b [8];
  logic [7:0] tcnt = '0;

  always #5 clk = ~clk;
  always @(negedge clk) tcnt <= tcnt + 8'd1;

  // External 8:1 muxes driven by the DUT selects.
  always_comb begin
    case (cls_a[sel_a])
      2'd0:    ro_a = 1'b0;
      2'd1:    ro_a = tcnt[2];
      2'd2:    ro_a = tcnt[1];
      default: ro_a = tcnt[0];
    endcase
    case (cls_b[sel_b])
      2'd0:    ro_b = 1'b0;
      2'd1:    ro_b = tcnt[2];
      2'd2:    ro_b = tcnt[1];
      default: ro_b = tcnt[0];
    endcase
  end

  puf_eval_ctrl #(.N_BITS(NB), .WINDOW_CYCLES(WC), .SETTLE_CYCLES(SC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .chall_in(chall_in), .ro_a(ro_a), .ro_b(ro_b),
    .sel_a(sel_a), .sel_b(sel_b), .ro_en(ro_en), .busy(busy), .ready(ready),
    .response(response)
`ifdef PUF_TIE_FLAG_EN
    , .tie_mask(tie_mask)
`endif
  );

  puf_eval_ctrl #(.N_BITS(NB), .WINDOW_CYCLES(WC), .SETTLE_CYCLES(SC), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .chall_in(chall_in), .ro_a(ro_a), .ro_b(ro_b),
    .sel_a(s_sel_a), .sel_b(s_sel_b), .ro_en(s_ro_en), .busy(s_busy), .ready(s_ready),
    .response(s_response)
`ifdef PUF_TIE_FLAG_EN
    , .tie_mask(s_tie_mask)
`endif
  );

  function automatic logic [7:0] model_resp(input logic [7:0] c);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      r[i] = cls_a[(int'(c[2:0]) + i) % 8] > cls_b[(int'(c[7:5]) + i) % 8];
    return r;
  endfunction

  function automatic logic [7:0] model_tie(input logic [7:0] c);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      r[i] = cls_a[(int'(c[2:0]) + i) % 8] == cls_b[(int'(c[7:5]) + i) % 8];
    return r;
  endfunction

  task automatic set_classes(input int a, input int b);
    for (int j = 0; j < 8; j++) begin
      cls_a[j] = 2'(a);
      cls_b[j] = 2'(b);
    end
  endtask

  // Presents start for one edge (E0); returns at the negedge just after E0.
  task automatic start_eval(input logic [7:0] c);
    @(negedge clk);
    start    = 1'b1;
    chall_in = c;
    @(negedge clk);
    start    = 1'b0;
    chall_in = 8'($urandom);
  endtask

  // Waits for ready (k0 = cycles already elapsed since E0) and checks the finished evaluation.
  task automatic finish_eval(input logic [7:0] c, input int k0, input string name);
    int         lat;
    logic [7:0] er, et;
    er  = model_resp(c);
    et  = model_tie(c);
    lat = k0;
    while (ready !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== DONE_LAT) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, DONE_LAT);
    end
    total++;
    if (response !== er) begin
      bad++;
      $display("FAIL %s response: got %h want %h", name, response, er);
    end
    total++;
    if (s_response !== er) begin
      bad++;
      $display("FAIL %s sat_response: got %h want %h", name, s_response, er);
    end
    total++;
    if ({busy, ready, s_busy, s_ready} !== 4'b0101) begin
      bad++;
      $display("FAIL %s busy/ready: got %b want 0101", name, {busy, ready, s_busy, s_ready});
    end
`ifdef PUF_TIE_FLAG_EN
    total++;
    if (tie_mask !== et || s_tie_mask !== et) begin
      bad++;
      $display("FAIL %s tie_mask: got %h/%h want %h", name, tie_mask, s_tie_mask, et);
    end
`else
    if (et === 8'hxx) $display("model_tie undefined for %s", name);
`endif
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    start    = 1'b1;
    chall_in = 8'hFF;
    set_classes(3, 1);
    repeat (4) @(negedge clk);
    total++;
    if ({sel_a, sel_b, ro_en, busy, ready, response} !== '0) begin
      bad++;
      $display("FAIL reset outputs: got %h want 0", {sel_a, sel_b, ro_en, busy, ready, response});
    end
    total++;
    if ({s_sel_a, s_sel_b, s_ro_en, s_busy, s_ready, s_response} !== '0) begin
      bad++;
      $display("FAIL reset sat outputs: got %h want 0", {s_sel_a, s_sel_b, s_ro_en, s_busy, s_ready, s_response});
    end
`ifdef PUF_TIE_FLAG_EN
    total++;
    if (tie_mask !== 8'h00) begin
      bad++;
      $display("FAIL reset tie_mask: got %h want 00", tie_mask);
    end
`endif
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, ready, ro_en} !== 3'b000) begin
      bad++;
      $display("FAIL idle after reset: got %b want 000", {busy, ready, ro_en});
    end
  endtask

  task automatic test_bank_a_faster();
    set_classes(3, 1);
    start_eval(8'h00);
    total++;
    if ({busy, ready, ro_en} !== 3'b101) begin
      bad++;
      $display("FAIL a_faster start: got %b want 101", {busy, ready, ro_en});
    end
    finish_eval(8'h00, 0, "a_faster");
  endtask

  task automatic test_selects();
    set_classes(1, 3);
    start_eval(8'hA5);
    for (int k = 0; k < NB * BIT_CYC; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (sel_a !== 3'((5 + k / BIT_CYC) % 8) || sel_b !== 3'((5 + k / BIT_CYC) % 8)) begin
        bad++;
        $display("FAIL selects k=%0d: got %0d/%0d want %0d", k, sel_a, sel_b, (5 + k / BIT_CYC) % 8);
      end
      total++;
      if (ro_en !== (k % BIT_CYC != BIT_CYC - 1) || busy !== 1'b1) begin
        bad++;
        $display("FAIL ro_en/busy k=%0d: got %b%b want %b1", k, ro_en, busy, k % BIT_CYC != BIT_CYC - 1);
      end
    end
    finish_eval(8'hA5, NB * BIT_CYC - 1, "selects");
  endtask

  task automatic test_ties();
    set_classes(2, 2);
    start_eval(8'h3C);
    finish_eval(8'h3C, 0, "ties");
  endtask

  task automatic test_saturation();
    logic [7:0] c;
    c = 8'($urandom);
    set_classes(3, 0);
    start_eval(c);
    finish_eval(c, 0, "sat_vs_static");
    set_classes(3, 3);
    start_eval(c);
    finish_eval(c, 0, "sat_tie");
  endtask

  task automatic test_back_to_back();
    logic [7:0] c;
    c = 8'h5A;
    for (int j = 0; j < 8; j++) begin
      cls_a[j] = 2'(j % 4);
      cls_b[j] = 2'(3 - j % 4);
    end
    // Second start with a different challenge while busy must be ignored.
    start_eval(c);
    repeat (40) @(negedge clk);
    start    = 1'b1;
    chall_in = ~c;
    @(negedge clk);
    start    = 1'b0;
    finish_eval(c, 41, "busy_start");
  endtask

  task automatic test_retrigger();
    logic [7:0] c;
    c = 8'hC3;
    for (int j = 0; j < 8; j++) begin
      cls_a[j] = 2'($urandom_range(0, 3));
      cls_b[j] = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    start    = 1'b1;
    chall_in = c;
    @(negedge clk);
    finish_eval(c, 0, "retrig_first");
    @(negedge clk);
    total++;
    if ({busy, ready, response} !== {2'b10, 8'h00}) begin
      bad++;
      $display("FAIL retrigger restart: got %b/%h want 10/00", {busy, ready}, response);
    end
    start = 1'b0;
    finish_eval(c, 0, "retrig_second");
  endtask

  task automatic test_abort();
    logic [7:0] c;
    c = 8'($urandom);
    set_classes(3, 2);
    start_eval(c);
    repeat (3 * BIT_CYC + 5) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({sel_a, sel_b, ro_en, busy, ready, response} !== '0) begin
      bad++;
      $display("FAIL abort outputs: got %h want 0", {sel_a, sel_b, ro_en, busy, ready, response});
    end
    total++;
    if ({s_busy, s_ready, s_response} !== '0) begin
      bad++;
      $display("FAIL abort sat outputs: got %h want 0", {s_busy, s_ready, s_response});
    end
    @(negedge clk);
    rst = 1'b1;
    c = 8'($urandom);
    for (int j = 0; j < 8; j++) begin
      cls_a[j] = 2'($urandom_range(0, 3));
      cls_b[j] = 2'($urandom_range(0, 3));
    end
    start_eval(c);
    finish_eval(c, 0, "after_abort");
  endtask

  task automatic test_random();
    logic [7:0] c;
    for (int n = 0; n < 5; n++) begin
      c = 8'($urandom);
      for (int j = 0; j < 8; j++) begin
        cls_a[j] = 2'($urandom_range(0, 3));
        cls_b[j] = 2'($urandom_range(0, 3));
      end
      start_eval(c);
      finish_eval(c, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_bank_a_faster();
    test_selects();
    test_ties();
    test_saturation();
    test_back_to_back();
    test_retrigger();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
